// File: rtl/led_button_ctrl.sv
// led_button_ctrl
//   Button-to-LED controller for the Go Board front panel. Each of the NUM_CH
//   channels synchronises and debounces a raw push-button. Its LED either
//   follows the debounced level (mode = 0) or flips on every press
//   (mode = 1). The debounced level and a one-cycle press strobe are also
//   exported for downstream logic.
//
//   Optional feature (compile-time macro LED_BUTTON_CTRL_BLINK_MODE_EN):
//   adds input blink_en and a shared blink phase. A channel in toggle mode
//   whose toggle state is on and whose blink_en is set shows the blink phase
//   instead of a steady on.
//
// Ports
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   btn         : raw button levels (1 = pressed), asynchronous to clk
//   mode        : per-channel mode, 0 = follow, 1 = toggle
//   blink_en    : per-channel blink enable (only with the blink macro)
//   led         : registered LED drive (1 = on)
//   btn_state   : registered debounced button level
//   press_pulse : one-cycle strobe on each debounced rising edge
module led_button_ctrl #(
    parameter int NUM_CH            = 4,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int BLINK_HALF_PERIOD = 6250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn,
    input  logic [NUM_CH-1:0] mode,
`ifdef LED_BUTTON_CTRL_BLINK_MODE_EN
    input  logic [NUM_CH-1:0] blink_en,
`endif
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] btn_state,
    output logic [NUM_CH-1:0] press_pulse
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (NUM_CH < 1 || NUM_CH > 32 || DEBOUNCE_CYCLES < 2 || BLINK_HALF_PERIOD < 1) begin : g_bad_params
        $error("led_button_ctrl: parameter out of range");
    end

    logic [NUM_CH-1:0] sync_p0;
    logic [NUM_CH-1:0] sync_p1;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] toggle;
    logic [NUM_CH-1:0] on_level;

    // Stage 0/1: two-flop synchroniser on the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Stage 2: debounce. The counter only runs while the synchronised level
    // disagrees with the accepted level, so any glitch back restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            btn_state   <= '0;
            press_pulse <= '0;
            toggle      <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                press_pulse[i] <= 1'b0;
                if (sync_p1[i] == btn_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    cnt[i]       <= '0;
                    btn_state[i] <= sync_p1[i];
                    if (sync_p1[i]) begin
                        press_pulse[i] <= 1'b1;
                        // Toggle state only advances on presses seen in toggle mode.
                        if (mode[i]) begin
                            toggle[i] <= ~toggle[i];
                        end
                    end
                end
            end
        end
    end

`ifdef LED_BUTTON_CTRL_BLINK_MODE_EN
    localparam int              PH_W   = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(BLINK_HALF_PERIOD - 1);

    logic [PH_W-1:0] ph_cnt;
    logic            phase;

    // Shared free-running blink phase, flips every BLINK_HALF_PERIOD cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_cnt <= '0;
            phase  <= 1'b0;
        end else if (ph_cnt == PH_MAX) begin
            ph_cnt <= '0;
            phase  <= ~phase;
        end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
        end
    end

    // Blinking channels substitute the phase for a steady on.
    always_comb begin
        on_level = toggle & ~(blink_en & ~{NUM_CH{phase}});
    end
`else
    always_comb begin
        on_level = toggle;
    end
`endif

    // Stage 3: LED register, selected per channel by the current mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= (mode & on_level) | (~mode & btn_state);
        end
    end

endmodule

// File: tb/tb_led_button_ctrl.sv
module tb_led_button_ctrl;

    localparam int NUM_CH = 4;
    localparam int D      = 4;
    localparam int HALF   = 8;
`ifdef LED_BUTTON_CTRL_BLINK_MODE_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] btn = '0;
    logic [NUM_CH-1:0] mode = '0;
    logic [NUM_CH-1:0] blink_en = '0;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] btn_state;
    logic [NUM_CH-1:0] press_pulse;

    int tests = 0;
    int fails = 0;
    int pulse_cnt [NUM_CH];

    always #5 clk = ~clk;

    led_button_ctrl #(
        .NUM_CH(NUM_CH),
        .DEBOUNCE_CYCLES(D),
        .BLINK_HALF_PERIOD(HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .mode(mode),
`ifdef LED_BUTTON_CTRL_BLINK_MODE_EN
        .blink_en(blink_en),
`endif
        .led(led),
        .btn_state(btn_state),
        .press_pulse(press_pulse)
    );

    // ---------------- behavioural reference model ----------------
    // Edges are numbered from reset release. The level seen by the debouncer
    // at edge k is the raw button sampled two edges earlier. A level is
    // accepted once the last D seen levels all differ from the accepted one
    // and at least D edges have passed since the previous acceptance.
    logic [NUM_CH-1:0] bhist [64];
    int                n;
    int                last_chg [NUM_CH];
    logic [NUM_CH-1:0] m_stable, m_t, m_led, m_pulse;

    function automatic logic [NUM_CH-1:0] seen(input int k);
        if (k - 2 < 1) return '0;
        return bhist[(k - 2) & 63];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n        = 0;
            m_stable = '0;
            m_t      = '0;
            m_led    = '0;
            m_pulse  = '0;
            for (int c = 0; c < NUM_CH; c++) last_chg[c] = 0;
        end else begin
            logic              p_old;
            logic [NUM_CH-1:0] be;
            logic [NUM_CH-1:0] sv;
            bit                all_diff;
            n = n + 1;
            bhist[n & 63] = btn;
            p_old = (((n - 1) / HALF) % 2) == 1;
            be = BLINK ? blink_en : '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (mode[c]) m_led[c] = m_t[c] ? (be[c] ? p_old : 1'b1) : 1'b0;
                else         m_led[c] = m_stable[c];
            end
            m_pulse = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (n - last_chg[c] >= D) begin
                    all_diff = 1'b1;
                    for (int k = n - D + 1; k <= n; k++) begin
                        sv = seen(k);
                        if (sv[c] == m_stable[c]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_stable[c] = ~m_stable[c];
                        last_chg[c] = n;
                        if (m_stable[c]) begin
                            m_pulse[c] = 1'b1;
                            if (mode[c]) m_t[c] = ~m_t[c];
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(posedge clk) begin
        #1;
        tests++;
        if (led !== m_led || btn_state !== m_stable || press_pulse !== m_pulse) begin
            fails++;
            $display("FAIL model_cycle t=%0t: led/state/pulse got %h/%h/%h expected %h/%h/%h",
                     $time, led, btn_state, press_pulse, m_led, m_stable, m_pulse);
        end
        for (int c = 0; c < NUM_CH; c++) if (press_pulse[c] === 1'b1) pulse_cnt[c]++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_pulse(input int c);
        int i;
        i = 0;
        while (press_pulse[c] !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("pulse_wait", {31'd0, press_pulse[c]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int last_tr;
        int ntr;
        logic prev;
        for (int c = 0; c < NUM_CH; c++) pulse_cnt[c] = 0;

        // Reset values, then immediate clear mid-count.
        tick(2);
        check("reset_led", {28'd0, led}, 32'h0);
        check("reset_state", {28'd0, btn_state}, 32'h0);
        rst = 1'b0;
        btn = 4'hF;
        tick(9);
        check("first_state", {28'd0, btn_state}, 32'hF);
        check("first_led", {28'd0, led}, 32'hF);
        btn = 4'h0;
        tick(3);
        rst = 1'b1;
        btn = 4'hF;
        #1;
        check("rst_imm_led", {28'd0, led}, 32'h0);
        check("rst_imm_state", {28'd0, btn_state}, 32'h0);
        check("rst_imm_pulse", {28'd0, press_pulse}, 32'h0);
        tick(1);
        rst = 1'b0;
        tick(5);
        check("rel_state_e5", {28'd0, btn_state}, 32'h0);
        tick(1);
        check("rel_state_e6", {28'd0, btn_state}, 32'hF);
        check("rel_pulse_e6", {28'd0, press_pulse}, 32'hF);
        tick(1);
        check("rel_pulse_e7", {28'd0, press_pulse}, 32'h0);
        check("rel_led_e7", {28'd0, led}, 32'hF);
        btn = 4'h0;
        tick(10);

        // Follow latency on channel 0.
        btn[0] = 1'b1;
        tick(5);
        check("follow_state_e5", {31'd0, btn_state[0]}, 32'd0);
        tick(1);
        check("follow_state_e6", {31'd0, btn_state[0]}, 32'd1);
        check("follow_led_e6", {31'd0, led[0]}, 32'd0);
        tick(1);
        check("follow_led_e7", {31'd0, led[0]}, 32'd1);
        tick(3);
        snap = pulse_cnt[0];
        btn[0] = 1'b0;
        tick(6);
        check("release_state_e6", {31'd0, btn_state[0]}, 32'd0);
        check("release_led_e6", {31'd0, led[0]}, 32'd1);
        tick(1);
        check("release_led_e7", {31'd0, led[0]}, 32'd0);
        check("release_no_pulse", pulse_cnt[0], snap);

        // Glitch rejection on channel 1.
        snap = pulse_cnt[1];
        repeat (5) begin
            btn[1] = 1'b1;
            tick(3);
            btn[1] = 1'b0;
            tick(3);
        end
        tick(8);
        check("glitch_pulses", pulse_cnt[1], snap);
        check("glitch_state", {31'd0, btn_state[1]}, 32'd0);
        check("glitch_led", {31'd0, led[1]}, 32'd0);

        // Toggle mode on channel 2: led sequence 1, 0, 1.
        mode = 4'b0100;
        snap = pulse_cnt[2];
        for (int i = 0; i < 3; i++) begin
            btn[2] = 1'b1;
            wait_pulse(2);
            tick(1);
            check("toggle_led", {31'd0, led[2]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("toggle_single", {31'd0, press_pulse[2]}, 32'd0);
            tick(4);
            btn[2] = 1'b0;
            tick(10);
        end
        check("toggle_pulse_count", pulse_cnt[2] - snap, 32'd3);

        // Mode switch with the toggle state on.
        mode[2] = 1'b0;
        tick(1);
        check("mode_to_follow", {31'd0, led[2]}, 32'd0);
        mode[2] = 1'b1;
        tick(1);
        check("mode_to_toggle", {31'd0, led[2]}, 32'd1);

        // Simultaneous presses on channels 0 and 3.
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        wait_pulse(0);
        check("simul_pulse", {28'd0, press_pulse & 4'b1001}, 32'h9);
        tick(3);
        btn = 4'h0;
        tick(10);

`ifdef LED_BUTTON_CTRL_BLINK_MODE_EN
        // Blink on channel 3 once its toggle state is on.
        mode[3] = 1'b1;
        btn[3] = 1'b1;
        wait_pulse(3);
        tick(2);
        btn[3] = 1'b0;
        tick(8);
        check("blink_pre_led", {31'd0, led[3]}, 32'd1);
        blink_en[3] = 1'b1;
        tick(1);
        prev = led[3];
        last_tr = -1;
        ntr = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (led[3] !== prev) begin
                if (last_tr >= 0) check("blink_gap", i - last_tr, 32'd8);
                last_tr = i;
                ntr++;
                prev = led[3];
            end
        end
        check("blink_transitions", {31'd0, ntr >= 3}, 32'd1);
        blink_en[3] = 1'b0;
        tick(1);
        check("blink_off_led", {31'd0, led[3]}, 32'd1);
`else
        last_tr = 0;
        ntr = 0;
        prev = 1'b0;
`endif

        // Randomised traffic checked cycle by cycle against the model.
        for (int seg = 0; seg < 300; seg++) begin
            btn = 4'($urandom);
            if ($urandom_range(0, 7) == 0) mode = 4'($urandom);
            if ($urandom_range(0, 5) == 0) blink_en = 4'($urandom);
            if (seg == 150) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            tick($urandom_range(1, 8));
        end
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_button_ctrl.md
Name: led_button_ctrl

Overview:
- Parametrised button-to-LED controller for the Go Board front panel; successor to the direct button-to-LED wiring.
- NUM_CH channels.
- Each channel synchronises and debounces a raw push-button.
- Each channel drives its LED in one of two modes:
  - follow: LED shows the debounced level.
  - toggle: each press flips the LED.
- Also exports a debounced level and a one-cycle press pulse for downstream logic.

Parameters:
- NUM_CH, 4: number of button/LED channels, 1..32.
- DEBOUNCE_CYCLES, 250000: consecutive cycles a synchronised level must hold before it is accepted. Default is 10 ms at 25 MHz. Legal range 2..2^24.
- CNT_W: localparam = clog2(DEBOUNCE_CYCLES); width of each debounce counter. Not overridable.
- BLINK_HALF_PERIOD, 6250000: half-period in cycles of the shared blink phase. Used only with BLINK_MODE_EN.

Ports:
- clk, input, 1: system clock (25 MHz on Go Board).
- rst, input, 1: asynchronous, active-high reset.
- btn, input, NUM_CH: raw button levels (1 = pressed); asynchronous to clk.
- mode, input, NUM_CH: per-channel mode, 0 = follow, 1 = toggle. Quasi-static; sampled every cycle.
- led, output, NUM_CH: registered LED drive (1 = on).
- btn_state, output, NUM_CH: registered debounced button level.
- press_pulse, output, NUM_CH: one-cycle strobe on each debounced rising edge.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Clears sync flops, debounce counters, stable levels, toggle state and blink phase.
  - led = 0, btn_state = 0, press_pulse = 0.
  - An in-progress debounce is discarded; no pulse is generated on reset release.
- Synchroniser: two flops per channel. s = second-stage output.
- Debounce, per channel, with stable = btn_state:
  - s == stable: counter <= 0.
  - s != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s != stable and counter == DEBOUNCE_CYCLES-1: stable <= s, counter <= 0.
  - Any glitch that returns s to stable before acceptance restarts the count from 0.
- Latency:
  - A clean input change shows on btn_state exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
  - led follows one edge later, at DEBOUNCE_CYCLES+3.
- press_pulse:
  - Registered; high for exactly one cycle.
  - Asserted in the same cycle btn_state first reads 1 after a 0.
  - No pulse on release.
- Toggle state (t):
  - In toggle mode (mode = 1), t flips on the same edge that sets press_pulse.
  - In follow mode, t holds its value.
  - t survives mode changes; only rst clears it.
- led register, updated every edge:
  - mode = 0: led <= btn_state.
  - mode = 1: led <= t.
  - A mode change takes effect on the next edge; the transition has no pulse and no glitch.
- Channel independence: channels share only clk/rst (and the blink phase, when compiled in). Simultaneous presses on all channels are handled independently, with identical latency.
- Counter width: no overflow is possible, because the counter never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: LED_BUTTON_CTRL_BLINK_MODE_EN.
- Defined:
  - Adds input blink_en [NUM_CH].
  - Adds a shared free-running phase counter. The phase bit p flips every BLINK_HALF_PERIOD cycles and resets to 0 with the counter.
  - A channel with mode = 1, t = 1 and blink_en = 1 drives led <= p instead of 1.
  - All other cases behave as without the macro.
  - blink_en has no effect in follow mode.
- Undefined:
  - Port blink_en, the phase counter and BLINK_HALF_PERIOD usage are all absent.
  - Behaviour is exactly as in the Behaviour section above.

Test Plan (DEBOUNCE_CYCLES = 4, BLINK_HALF_PERIOD = 8, NUM_CH = 4):
- Reset values: assert rst mid-count with btn = 4'hF -> led, btn_state, press_pulse all 0 immediately. After release, holding btn steady gives btn_state = 4'hF 6 edges later and press_pulse = 4'hF for 1 cycle.
- Follow latency: mode = 0, btn[0] 0->1 held -> btn_state[0] = 1 at edge 6, led[0] = 1 at edge 7. Release -> led[0] = 0 at edge 7 after release, no press_pulse.
- Glitch rejection: btn[1] pulses high for 3 cycles then low, repeated 5 times -> btn_state[1], led[1], press_pulse[1] stay 0 throughout.
- Toggle mode: mode = 4'b0100, three clean presses on btn[2] -> led[2] sequence 1, 0, 1; press_pulse[2] exactly 3 single-cycle strobes.
- Mode switch / independence: with t[2] = 1, set mode[2] = 0 while released -> led[2] = 0 next edge. Set mode[2] = 1 -> led[2] = 1 next edge. Simultaneous presses on channels 0 and 3 -> both strobe on the same cycle.
- Blink (macro defined): mode[3] = 1, t[3] = 1, blink_en[3] = 1 -> led[3] toggles every 8 cycles. Clearing blink_en[3] -> led[3] = 1 next edge.
